// File: rtl/bk_sector_sequencer_if.sv
// SD block handshake between the backup sequencer (master) and hps_io (slave).
// The sequencer drives the sector address and one-hot read/write strobes;
// hps_io answers with sd_ack, held high while a sector is being moved.
interface bk_sector_sequencer_if;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;

  modport master (
    output sd_lba,
    output sd_rd,
    output sd_wr,
    input  sd_ack
  );

  modport slave (
    input  sd_lba,
    input  sd_rd,
    input  sd_wr,
    output sd_ack
  );
endinterface

// File: rtl/bk_sector_sequencer.sv
// Backup RAM sector sequencer: walks every sector of one save slot, issuing a
// read (load) or write (save) strobe per sector and waiting for the HPS ack
// pulse. Tracks save-image usability, flags ack timeouts and aborts when a
// new ROM download starts.
module bk_sector_sequencer #(
  parameter int SEC_W  = 6,
  parameter int SLOT_W = 2,
  parameter int TMO_W  = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              downloading,
  input  logic              img_mounted,
  input  logic              img_size_nz,
  input  logic              img_readonly,
  input  logic              load_req,
  input  logic              save_req,
  input  logic [SLOT_W-1:0] slot,
  bk_sector_sequencer_if.master sd,
  output logic              bk_ena,
  output logic              bk_busy,
  output logic              bk_loading,
  output logic              bk_done,
  output logic              bk_error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_XFER
  } state_t;

  // Watchdog value one step before all-ones: the timeout fires as the
  // counter would reach all-ones, i.e. after 2^TMO_W-1 silent cycles.
  localparam logic [TMO_W-1:0] WDOG_PRE_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  state_t            r_state;
  logic [SLOT_W-1:0] r_slot;
  logic [SEC_W-1:0]  r_sector;
  logic              r_rd;
  logic              r_wr;
  logic              r_is_load;
  logic              r_busy;
  logic              r_loading;
  logic              r_done;
  logic              r_error;
  logic [TMO_W-1:0]  r_wdog;

  logic              r_bk_ena;
  logic              r_dl_old;
  logic              r_old_load;
  logic              r_old_save;
  logic              r_ack_old;

  logic              w_dl_rise;
  logic              w_ena_set;
  logic              w_load_edge;
  logic              w_save_edge;
  logic              w_req_edge;
  logic              w_ack_rise;
  logic              w_ack_fall;
  logic              w_ack_edge;
  logic              w_last_sector;
  logic              w_wdog_expire;

  assign w_dl_rise     = downloading & ~r_dl_old;
  assign w_ena_set     = downloading & img_mounted & img_size_nz & ~img_readonly;

  // Requests only count while a usable image is mounted; the history
  // register is gated the same way so enabling mid-level yields an edge.
  assign w_load_edge   = load_req & r_bk_ena & ~r_old_load;
  assign w_save_edge   = save_req & r_bk_ena & ~r_old_save;
  assign w_req_edge    = w_load_edge | w_save_edge;

  // Ack edges are taken against the registered copy, so an ack level that
  // is already high when a strobe goes out is not mistaken for a response.
  assign w_ack_rise    = sd.sd_ack & ~r_ack_old;
  assign w_ack_fall    = ~sd.sd_ack & r_ack_old;
  assign w_ack_edge    = w_ack_rise | w_ack_fall;

  assign w_last_sector = &r_sector;
  assign w_wdog_expire = (r_wdog == WDOG_PRE_LAST);

  // Image-enable flag plus edge-detect history for downloading, requests and ack.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bk_ena   <= 1'b0;
      r_dl_old   <= 1'b0;
      r_old_load <= 1'b0;
      r_old_save <= 1'b0;
      r_ack_old  <= 1'b0;
    end else begin
      r_dl_old   <= downloading;
      r_old_load <= load_req & r_bk_ena;
      r_old_save <= save_req & r_bk_ena;
      r_ack_old  <= sd.sd_ack;
      // A mount seen in the same cycle as the download start keeps the image enabled.
      if (w_ena_set) begin
        r_bk_ena <= 1'b1;
      end else if (w_dl_rise) begin
        r_bk_ena <= 1'b0;
      end
    end
  end

  // Transfer FSM: accept, strobe/ack per sector, completion, timeout and abort.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_slot    <= '0;
      r_sector  <= '0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_is_load <= 1'b0;
      r_busy    <= 1'b0;
      r_loading <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_wdog    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Load wins when both requests arrive together.
          if (w_req_edge) begin
            r_state   <= S_REQ;
            r_slot    <= slot;
            r_sector  <= '0;
            r_is_load <= w_load_edge;
            r_rd      <= w_load_edge;
            r_wr      <= ~w_load_edge;
            r_busy    <= 1'b1;
            r_loading <= w_load_edge;
            r_error   <= 1'b0;
            r_wdog    <= '0;
          end
        end

        S_REQ, S_XFER: begin
          if (w_dl_rise) begin
            // A new ROM download abandons the transfer; any earlier error stays visible.
            r_state   <= S_IDLE;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_busy    <= 1'b0;
            r_loading <= 1'b0;
          end else if (w_ack_edge) begin
            r_wdog <= '0;
            if (r_state == S_REQ && w_ack_rise) begin
              r_rd    <= 1'b0;
              r_wr    <= 1'b0;
              r_state <= S_XFER;
            end else if (r_state == S_XFER && w_ack_fall) begin
              if (w_last_sector) begin
                r_state   <= S_IDLE;
                r_busy    <= 1'b0;
                r_loading <= 1'b0;
                r_done    <= 1'b1;
              end else begin
                // Only the sector field advances; the slot never changes mid-transfer.
                r_sector <= r_sector + 1'b1;
                r_rd     <= r_is_load;
                r_wr     <= ~r_is_load;
                r_state  <= S_REQ;
              end
            end
          end else if (w_wdog_expire) begin
            r_state   <= S_IDLE;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_busy    <= 1'b0;
            r_loading <= 1'b0;
            r_error   <= 1'b1;
            r_wdog    <= '1;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_rd    <= 1'b0;
          r_wr    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sd.sd_lba  = 32'({r_slot, r_sector});
  assign sd.sd_rd   = r_rd;
  assign sd.sd_wr   = r_wr;
  assign bk_ena     = r_bk_ena;
  assign bk_busy    = r_busy;
  assign bk_loading = r_loading;
  assign bk_done    = r_done;
  assign bk_error   = r_error;

endmodule
